// File: rtl/mmu_tlb_if.sv
// Lookup request/result bundle between the pipeline (master) and the TLB (slave).
// Signal names keep the TLB-side direction suffixes.
interface mmu_tlb_if;
  logic        inst_req_i;
  logic [31:0] inst_vaddr_i;
  logic [31:0] inst_paddr_o;
  logic        inst_valid_o;
  logic        inst_miss_o;
  logic        inst_invalid_o;

  logic        data_req_i;
  logic        data_we_i;
  logic [31:0] data_vaddr_i;
  logic [31:0] data_paddr_o;
  logic        data_valid_o;
  logic        data_miss_o;
  logic        data_invalid_o;
  logic        data_modified_o;

  modport master (
    output inst_req_i, inst_vaddr_i, data_req_i, data_we_i, data_vaddr_i,
    input  inst_paddr_o, inst_valid_o, inst_miss_o, inst_invalid_o,
    input  data_paddr_o, data_valid_o, data_miss_o, data_invalid_o, data_modified_o
  );

  modport slave (
    input  inst_req_i, inst_vaddr_i, data_req_i, data_we_i, data_vaddr_i,
    output inst_paddr_o, inst_valid_o, inst_miss_o, inst_invalid_o,
    output data_paddr_o, data_valid_o, data_miss_o, data_invalid_o, data_modified_o
  );
endinterface

// File: rtl/mmu_tlb.sv
// Joint instruction/data TLB: entry array written by TLBWI/TLBWR, registered
// fetch and load/store translation, combinational TLBP/TLBR for CP0.
module mmu_tlb #(
  parameter int TLB_ENTRY_NUM = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic            flush_i,
  mmu_tlb_if.slave        lk,
  input  logic            tlbwi_i,
  input  logic            tlbwr_i,
  input  logic            tlbp_i,
  input  logic            tlbr_i,
  input  logic [31:0]     index_i,
  input  logic [31:0]     random_i,
  input  logic [31:0]     entryhi_i,
  input  logic [31:0]     entrylo0_i,
  input  logic [31:0]     entrylo1_i,
  output logic            tlbr_op_o,
  output logic [31:0]     entryhi_o,
  output logic [31:0]     entrylo0_o,
  output logic [31:0]     entrylo1_o,
  output logic            tlbp_op_o,
  output logic [31:0]     index_o
);
  localparam int IDX_W = $clog2(TLB_ENTRY_NUM);

  typedef struct packed {
    logic [31:0] paddr;
    logic        miss;
    logic        invalid;
    logic        modified;
  } xlate_t;

  typedef struct packed {
    logic   valid;
    xlate_t x;
  } res_t;

  logic [18:0] vpn2_q [TLB_ENTRY_NUM];
  logic [7:0]  asid_q [TLB_ENTRY_NUM];
  logic        g_q    [TLB_ENTRY_NUM];
  logic [19:0] pfn_q  [TLB_ENTRY_NUM][2];
  logic [2:0]  c_q    [TLB_ENTRY_NUM][2];
  logic        d_q    [TLB_ENTRY_NUM][2];
  logic        v_q    [TLB_ENTRY_NUM][2];

  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;

  assign wr_en  = tlbwi_i | tlbwr_i;
  assign wr_idx = tlbwi_i ? index_i[IDX_W-1:0] : random_i[IDX_W-1:0];
  assign rd_idx = index_i[IDX_W-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < TLB_ENTRY_NUM; i++) begin
        vpn2_q[i] <= '0;
        asid_q[i] <= '0;
        g_q[i]    <= 1'b0;
        for (int h = 0; h < 2; h++) begin
          pfn_q[i][h] <= '0;
          c_q[i][h]   <= '0;
          d_q[i][h]   <= 1'b0;
          v_q[i][h]   <= 1'b0;
        end
      end
    end else if (wr_en) begin
      vpn2_q[wr_idx]   <= entryhi_i[31:13];
      asid_q[wr_idx]   <= entryhi_i[7:0];
      g_q[wr_idx]      <= entrylo0_i[0] & entrylo1_i[0];
      pfn_q[wr_idx][0] <= entrylo0_i[25:6];
      c_q[wr_idx][0]   <= entrylo0_i[5:3];
      d_q[wr_idx][0]   <= entrylo0_i[2];
      v_q[wr_idx][0]   <= entrylo0_i[1];
      pfn_q[wr_idx][1] <= entrylo1_i[25:6];
      c_q[wr_idx][1]   <= entrylo1_i[5:3];
      d_q[wr_idx][1]   <= entrylo1_i[2];
      v_q[wr_idx][1]   <= entrylo1_i[1];
    end
  end

  // All three match vectors use the current CP0 ASID.
  logic [TLB_ENTRY_NUM-1:0] inst_match, data_match, probe_match;

  always_comb begin
    inst_match  = '0;
    data_match  = '0;
    probe_match = '0;
    for (int i = 0; i < TLB_ENTRY_NUM; i++) begin
      inst_match[i]  = (vpn2_q[i] == lk.inst_vaddr_i[31:13]) &&
                       (g_q[i] || asid_q[i] == entryhi_i[7:0]);
      data_match[i]  = (vpn2_q[i] == lk.data_vaddr_i[31:13]) &&
                       (g_q[i] || asid_q[i] == entryhi_i[7:0]);
      probe_match[i] = (vpn2_q[i] == entryhi_i[31:13]) &&
                       (g_q[i] || asid_q[i] == entryhi_i[7:0]);
    end
  end

  function automatic logic [IDX_W-1:0] first_idx(input logic [TLB_ENTRY_NUM-1:0] m);
    first_idx = '0;
    for (int i = TLB_ENTRY_NUM - 1; i >= 0; i--) begin
      if (m[i]) first_idx = IDX_W'(i);
    end
  endfunction

  function automatic xlate_t xlate(input logic [31:0] va, input logic store,
                                   input logic [TLB_ENTRY_NUM-1:0] m);
    logic [IDX_W-1:0] idx;
    logic             h;
    xlate = '0;
    idx   = first_idx(m);
    h     = va[12];
    // kseg0 and kseg1 both reduce to clearing the top three address bits.
    if (va[31:30] == 2'b10) begin
      xlate.paddr = {3'b000, va[28:0]};
    end else if (m == '0) begin
      xlate.miss = 1'b1;
    end else if (!v_q[idx][h]) begin
      xlate.invalid = 1'b1;
    end else if (store && !d_q[idx][h]) begin
      xlate.modified = 1'b1;
    end else begin
      xlate.paddr = {pfn_q[idx][h], va[11:0]};
    end
  endfunction

  xlate_t inst_x, data_x;
  res_t   inst_d, inst_q, data_d, data_q;

  assign inst_x = xlate(lk.inst_vaddr_i, 1'b0, inst_match);
  assign data_x = xlate(lk.data_vaddr_i, lk.data_we_i, data_match);

  always_comb begin
    inst_d = inst_q;
    data_d = data_q;
    if (flush_i) begin
      inst_d = '0;
      data_d = '0;
    end else if (!stall_i) begin
      inst_d.valid = lk.inst_req_i;
      inst_d.x     = lk.inst_req_i ? inst_x : '0;
      data_d.valid = lk.data_req_i;
      data_d.x     = lk.data_req_i ? data_x : '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inst_q <= '0;
      data_q <= '0;
    end else begin
      inst_q <= inst_d;
      data_q <= data_d;
    end
  end

  assign lk.inst_paddr_o    = inst_q.x.paddr;
  assign lk.inst_valid_o    = inst_q.valid;
  assign lk.inst_miss_o     = inst_q.x.miss;
  assign lk.inst_invalid_o  = inst_q.x.invalid;
  assign lk.data_paddr_o    = data_q.x.paddr;
  assign lk.data_valid_o    = data_q.valid;
  assign lk.data_miss_o     = data_q.x.miss;
  assign lk.data_invalid_o  = data_q.x.invalid;
  assign lk.data_modified_o = data_q.x.modified;

  assign tlbp_op_o = tlbp_i;
  assign index_o   = !tlbp_i        ? 32'h0 :
                     |probe_match   ? {{(32-IDX_W){1'b0}}, first_idx(probe_match)} :
                                      32'h8000_0000;

  assign tlbr_op_o  = tlbr_i;
  assign entryhi_o  = tlbr_i ? {vpn2_q[rd_idx], 5'b0, asid_q[rd_idx]} : 32'h0;
  assign entrylo0_o = tlbr_i ? {6'b0, pfn_q[rd_idx][0], c_q[rd_idx][0], d_q[rd_idx][0],
                                v_q[rd_idx][0], g_q[rd_idx]} : 32'h0;
  assign entrylo1_o = tlbr_i ? {6'b0, pfn_q[rd_idx][1], c_q[rd_idx][1], d_q[rd_idx][1],
                                v_q[rd_idx][1], g_q[rd_idx]} : 32'h0;

  logic unused_bits;
  assign unused_bits = ^{index_i[31:IDX_W], random_i[31:IDX_W], entryhi_i[12:8],
                         entrylo0_i[31:26], entrylo1_i[31:26]};
endmodule

// File: tb/tb_mmu_tlb.sv
// Bench for mmu_tlb: directed scenarios from the bring-up list plus a randomized
// run checked against an entry-table model of the TLB.
module tb_mmu_tlb;
  localparam int N = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        stall_i, flush_i, tlbwi_i, tlbwr_i, tlbp_i, tlbr_i;
  logic [31:0] index_i, random_i, entryhi_i, entrylo0_i, entrylo1_i;
  logic        tlbr_op_o, tlbp_op_o;
  logic [31:0] entryhi_o, entrylo0_o, entrylo1_o, index_o;

  mmu_tlb_if lk();

  mmu_tlb #(.TLB_ENTRY_NUM(N)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i), .lk(lk),
    .tlbwi_i(tlbwi_i), .tlbwr_i(tlbwr_i), .tlbp_i(tlbp_i), .tlbr_i(tlbr_i),
    .index_i(index_i), .random_i(random_i), .entryhi_i(entryhi_i),
    .entrylo0_i(entrylo0_i), .entrylo1_i(entrylo1_i),
    .tlbr_op_o(tlbr_op_o), .entryhi_o(entryhi_o), .entrylo0_o(entrylo0_o),
    .entrylo1_o(entrylo1_o), .tlbp_op_o(tlbp_op_o), .index_o(index_o)
  );

  int n_vec, n_err;

  // Model: entries kept as raw CP0 words (EntryLo with the G bit stripped).
  logic [18:0] m_vpn2 [N];
  logic [7:0]  m_asid [N];
  logic        m_g    [N];
  logic [31:0] m_lo   [N][2];

  logic        e_iv, e_imiss, e_iinv, e_dv, e_dmiss, e_dinv, e_dmod;
  logic [31:0] e_ipa, e_dpa;

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      m_vpn2[i] = '0; m_asid[i] = '0; m_g[i] = 1'b0; m_lo[i][0] = '0; m_lo[i][1] = '0;
    end
    {e_iv, e_imiss, e_iinv, e_dv, e_dmiss, e_dinv, e_dmod} = '0;
    e_ipa = '0; e_dpa = '0;
  endtask

  function automatic int model_find(input logic [18:0] vpn2, input logic [7:0] asid);
    for (int i = 0; i < N; i++)
      if (m_vpn2[i] == vpn2 && (m_g[i] || m_asid[i] == asid)) return i;
    return -1;
  endfunction

  function automatic void model_xlate(input logic [31:0] va, input logic we, input logic [7:0] asid,
                                      output logic [31:0] pa, output logic miss,
                                      output logic inv, output logic mod);
    int          hit;
    logic [31:0] lo;
    pa = '0; miss = 1'b0; inv = 1'b0; mod = 1'b0;
    if (va >= 32'h8000_0000 && va < 32'hA000_0000) begin pa = va - 32'h8000_0000; return; end
    if (va >= 32'hA000_0000 && va < 32'hC000_0000) begin pa = va - 32'hA000_0000; return; end
    hit = model_find(va[31:13], asid);
    if (hit < 0) begin miss = 1'b1; return; end
    lo = m_lo[hit][va[12]];
    if (!lo[1]) inv = 1'b1;
    else if (we && !lo[2]) mod = 1'b1;
    else pa = (((lo >> 6) & 32'hF_FFFF) << 12) | (va & 32'hFFF);
  endfunction

  task automatic clear_inputs();
    stall_i = 0; flush_i = 0; tlbwi_i = 0; tlbwr_i = 0; tlbp_i = 0; tlbr_i = 0;
    index_i = 0; random_i = 0; entryhi_i = 0; entrylo0_i = 0; entrylo1_i = 0;
    lk.inst_req_i = 0; lk.inst_vaddr_i = 0; lk.data_req_i = 0; lk.data_we_i = 0; lk.data_vaddr_i = 0;
  endtask

  task automatic set_lookup(input logic ireq, input logic [31:0] iva, input logic dreq,
                            input logic dwe, input logic [31:0] dva);
    lk.inst_req_i = ireq; lk.inst_vaddr_i = iva;
    lk.data_req_i = dreq; lk.data_we_i = dwe; lk.data_vaddr_i = dva;
  endtask

  task automatic set_write(input logic wi, input logic wr, input logic [31:0] idx, input logic [31:0] rnd,
                           input logic [31:0] hi, input logic [31:0] lo0, input logic [31:0] lo1);
    tlbwi_i = wi; tlbwr_i = wr; index_i = idx; random_i = rnd;
    entryhi_i = hi; entrylo0_i = lo0; entrylo1_i = lo1;
  endtask

  // One clock: model lookups use pre-write contents, writes land after the edge.
  task automatic step();
    logic [31:0] ipa, dpa;
    logic        im, ii, imod, dm, di, dmod;
    int          w;
    model_xlate(lk.inst_vaddr_i, 1'b0, entryhi_i[7:0], ipa, im, ii, imod);
    model_xlate(lk.data_vaddr_i, lk.data_we_i, entryhi_i[7:0], dpa, dm, di, dmod);
    @(posedge clk);
    if (flush_i) begin
      {e_iv, e_imiss, e_iinv, e_dv, e_dmiss, e_dinv, e_dmod} = '0;
    end else if (!stall_i) begin
      e_iv = lk.inst_req_i; e_ipa = ipa; e_imiss = lk.inst_req_i & im; e_iinv = lk.inst_req_i & ii;
      e_dv = lk.data_req_i; e_dpa = dpa; e_dmiss = lk.data_req_i & dm; e_dinv = lk.data_req_i & di;
      e_dmod = lk.data_req_i & dmod;
    end
    if (tlbwi_i || tlbwr_i) begin
      w = tlbwi_i ? int'(index_i % N) : int'(random_i % N);
      m_vpn2[w] = entryhi_i[31:13]; m_asid[w] = entryhi_i[7:0];
      m_g[w] = entrylo0_i[0] & entrylo1_i[0];
      m_lo[w][0] = entrylo0_i & 32'h03FF_FFFE; m_lo[w][1] = entrylo1_i & 32'h03FF_FFFE;
    end
    #1;
  endtask

  task automatic test_reset();
    n_vec++; if (lk.inst_valid_o !== 1'b0) begin n_err++; $display("FAIL rst_inst_valid: got %b exp 0", lk.inst_valid_o); end
    n_vec++; if (lk.data_valid_o !== 1'b0) begin n_err++; $display("FAIL rst_data_valid: got %b exp 0", lk.data_valid_o); end
    n_vec++; if ({lk.data_miss_o, lk.data_invalid_o, lk.data_modified_o, lk.inst_miss_o, lk.inst_invalid_o} !== 5'b0)
      begin n_err++; $display("FAIL rst_flags: got %b exp 0", {lk.data_miss_o, lk.data_invalid_o, lk.data_modified_o, lk.inst_miss_o, lk.inst_invalid_o}); end
    n_vec++; if ({lk.inst_paddr_o, lk.data_paddr_o} !== 64'h0) begin n_err++; $display("FAIL rst_paddr: got %h %h exp 0", lk.inst_paddr_o, lk.data_paddr_o); end
    rst = 1'b1;
    tlbr_i = 1; index_i = 7; #1;
    n_vec++; if (tlbr_op_o !== 1'b1) begin n_err++; $display("FAIL rst_tlbr_op: got %b exp 1", tlbr_op_o); end
    n_vec++; if ({entryhi_o, entrylo0_o, entrylo1_o} !== 96'h0) begin n_err++; $display("FAIL rst_entry: got %h %h %h exp 0", entryhi_o, entrylo0_o, entrylo1_o); end
    tlbr_i = 0; index_i = 0;
  endtask

  task automatic test_unmapped();
    set_lookup(1, 32'h9FC0_0000, 1, 0, 32'h0040_0000); step();
    n_vec++; if ({lk.data_valid_o, lk.data_miss_o} !== 2'b11) begin n_err++; $display("FAIL unmapped_dmiss: got v=%b miss=%b exp 1 1", lk.data_valid_o, lk.data_miss_o); end
    n_vec++; if (lk.data_paddr_o !== 32'h0) begin n_err++; $display("FAIL unmapped_dpaddr: got %h exp 0", lk.data_paddr_o); end
    n_vec++; if (lk.inst_paddr_o !== 32'h1FC0_0000) begin n_err++; $display("FAIL kseg0_paddr: got %h exp 1fc00000", lk.inst_paddr_o); end
    n_vec++; if ({lk.inst_valid_o, lk.inst_miss_o, lk.inst_invalid_o} !== 3'b100) begin n_err++; $display("FAIL kseg0_flags: got %b exp 100", {lk.inst_valid_o, lk.inst_miss_o, lk.inst_invalid_o}); end
    set_lookup(1, 32'hBFC0_0004, 0, 0, 0); step();
    n_vec++; if (lk.inst_paddr_o !== 32'h1FC0_0004) begin n_err++; $display("FAIL kseg1_paddr: got %h exp 1fc00004", lk.inst_paddr_o); end
    n_vec++; if (lk.data_valid_o !== 1'b0) begin n_err++; $display("FAIL noreq_valid: got %b exp 0", lk.data_valid_o); end
    set_lookup(0, 0, 0, 0, 0);
  endtask

  task automatic test_tlbwi();
    set_write(1, 0, 3, 0, 32'h0040_0005, 32'h0000_1006, 32'h0000_1042); step();
    tlbwi_i = 0;
    set_lookup(0, 0, 1, 0, 32'h0040_0ABC); step();
    n_vec++; if (lk.data_paddr_o !== 32'h0004_0ABC || lk.data_miss_o !== 1'b0) begin n_err++; $display("FAIL wi_load0: got %h miss=%b exp 00040abc 0", lk.data_paddr_o, lk.data_miss_o); end
    set_lookup(0, 0, 1, 1, 32'h0040_1ABC); step();
    n_vec++; if (lk.data_modified_o !== 1'b1 || lk.data_paddr_o !== 32'h0) begin n_err++; $display("FAIL wi_store_mod: got mod=%b pa=%h exp 1 0", lk.data_modified_o, lk.data_paddr_o); end
    set_lookup(0, 0, 1, 0, 32'h0040_1ABC); step();
    n_vec++; if (lk.data_paddr_o !== 32'h0004_1ABC || lk.data_modified_o !== 1'b0) begin n_err++; $display("FAIL wi_load1: got %h mod=%b exp 00041abc 0", lk.data_paddr_o, lk.data_modified_o); end
    set_lookup(0, 0, 0, 0, 0);
  endtask

  task automatic test_tlbp_tlbr();
    tlbp_i = 1; entryhi_i = 32'h0040_0005; #1;
    n_vec++; if (index_o !== 32'h3 || tlbp_op_o !== 1'b1) begin n_err++; $display("FAIL tlbp_hit: got %h op=%b exp 3 1", index_o, tlbp_op_o); end
    entryhi_i = 32'h7000_0005; #1;
    n_vec++; if (index_o !== 32'h8000_0000) begin n_err++; $display("FAIL tlbp_miss: got %h exp 80000000", index_o); end
    tlbp_i = 0; entryhi_i = 32'h0040_0005; tlbr_i = 1; index_i = 3; #1;
    n_vec++; if (entrylo0_o !== 32'h0000_1006 || entrylo1_o !== 32'h0000_1042) begin n_err++; $display("FAIL tlbr_lo: got %h %h exp 00001006 00001042", entrylo0_o, entrylo1_o); end
    n_vec++; if (entryhi_o !== 32'h0040_0005) begin n_err++; $display("FAIL tlbr_hi: got %h exp 00400005", entryhi_o); end
    n_vec++; if (index_o !== 32'h0) begin n_err++; $display("FAIL tlbp_idle: got %h exp 0", index_o); end
    tlbr_i = 0; #1;
    n_vec++; if (entryhi_o !== 32'h0 || tlbr_op_o !== 1'b0) begin n_err++; $display("FAIL tlbr_idle: got %h op=%b exp 0 0", entryhi_o, tlbr_op_o); end
  endtask

  task automatic test_asid_g();
    entryhi_i = 32'h0040_0006; set_lookup(0, 0, 1, 0, 32'h0040_0ABC); step();
    n_vec++; if (lk.data_miss_o !== 1'b1) begin n_err++; $display("FAIL asid_miss: got %b exp 1", lk.data_miss_o); end
    set_lookup(0, 0, 0, 0, 0);
    set_write(1, 0, 3, 0, 32'h0040_0005, 32'h0000_1007, 32'h0000_1043); step();
    tlbwi_i = 0; entryhi_i = 32'h0040_0006; set_lookup(0, 0, 1, 0, 32'h0040_0ABC); step();
    n_vec++; if (lk.data_miss_o !== 1'b0 || lk.data_paddr_o !== 32'h0004_0ABC) begin n_err++; $display("FAIL global_hit: got miss=%b pa=%h exp 0 00040abc", lk.data_miss_o, lk.data_paddr_o); end
    set_lookup(0, 0, 0, 0, 0); entryhi_i = 32'h0040_0005;
  endtask

  task automatic test_tlbwr();
    set_write(0, 1, 0, 15, 32'h0080_0005, 32'h0000_2002, 32'h0000_2042); step();
    tlbwr_i = 0; tlbr_i = 1; index_i = 15; #1;
    n_vec++; if (entryhi_o !== 32'h0080_0005 || entrylo0_o !== 32'h0000_2002) begin n_err++; $display("FAIL wr_entry15: got %h %h exp 00800005 00002002", entryhi_o, entrylo0_o); end
    index_i = 3; #1;
    n_vec++; if (entryhi_o !== 32'h0040_0005 || entrylo0_o !== 32'h0000_1007) begin n_err++; $display("FAIL wr_keeps3: got %h %h exp 00400005 00001007", entryhi_o, entrylo0_o); end
    tlbr_i = 0;
    set_write(1, 1, 2, 14, 32'h00A0_0005, 32'h0000_3002, 32'h0000_3042); step();
    tlbwi_i = 0; tlbwr_i = 0; tlbr_i = 1; index_i = 2; #1;
    n_vec++; if (entryhi_o !== 32'h00A0_0005) begin n_err++; $display("FAIL wiwr_entry2: got %h exp 00a00005", entryhi_o); end
    index_i = 14; #1;
    n_vec++; if (entryhi_o !== 32'h0 || entrylo0_o !== 32'h0) begin n_err++; $display("FAIL wiwr_entry14: got %h %h exp 0 0", entryhi_o, entrylo0_o); end
    tlbr_i = 0; index_i = 0; entryhi_i = 32'h0040_0005;
  endtask

  task automatic test_stall_flush();
    set_lookup(0, 0, 1, 0, 32'h0040_0ABC); step();
    stall_i = 1; set_lookup(1, 32'h0080_0000, 0, 1, 32'h0000_0000);
    for (int k = 0; k < 3; k++) begin
      step();
      n_vec++; if (lk.data_valid_o !== 1'b1 || lk.data_paddr_o !== 32'h0004_0ABC) begin n_err++; $display("FAIL stall_hold%0d: got v=%b pa=%h exp 1 00040abc", k, lk.data_valid_o, lk.data_paddr_o); end
    end
    flush_i = 1; step();
    n_vec++; if (lk.data_valid_o !== 1'b0 || lk.inst_valid_o !== 1'b0) begin n_err++; $display("FAIL flush_stall: got %b %b exp 0 0", lk.data_valid_o, lk.inst_valid_o); end
    stall_i = 0; flush_i = 0; set_lookup(0, 0, 0, 0, 0);
  endtask

  task automatic test_same_cycle_write();
    set_write(1, 0, 5, 0, 32'h00C0_0005, 32'h0000_4002, 32'h0000_4042);
    set_lookup(0, 0, 1, 0, 32'h00C0_0123); step();
    n_vec++; if (lk.data_miss_o !== 1'b1) begin n_err++; $display("FAIL same_cycle_miss: got %b exp 1", lk.data_miss_o); end
    tlbwi_i = 0; step();
    n_vec++; if (lk.data_miss_o !== 1'b0 || lk.data_paddr_o !== 32'h0010_0123) begin n_err++; $display("FAIL next_cycle_hit: got miss=%b pa=%h exp 0 00100123", lk.data_miss_o, lk.data_paddr_o); end
    set_lookup(0, 0, 0, 0, 0);
  endtask

  task automatic test_reset_mid();
    set_lookup(1, 32'h0040_0000, 1, 0, 32'h0040_0ABC); step();
    rst = 1'b0; #1;
    n_vec++; if (lk.data_valid_o !== 1'b0 || lk.inst_valid_o !== 1'b0) begin n_err++; $display("FAIL rst_mid_valid: got %b %b exp 0 0", lk.data_valid_o, lk.inst_valid_o); end
    clear_inputs(); model_clear();
    @(posedge clk); #1; rst = 1'b1;
    tlbr_i = 1; index_i = 3; #1;
    n_vec++; if (entrylo0_o !== 32'h0 || entryhi_o !== 32'h0) begin n_err++; $display("FAIL rst_mid_clear: got %h %h exp 0 0", entryhi_o, entrylo0_o); end
    tlbr_i = 0; index_i = 0;
  endtask

  function automatic logic [31:0] rand_va();
    logic [18:0] pool [4];
    pool[0] = 19'h00200; pool[1] = 19'h00201; pool[2] = 19'h60000; pool[3] = 19'h00000;
    if ($urandom_range(0, 3) == 0) return 32'h8000_0000 | ($urandom & 32'h3FFF_FFFF);
    return {pool[$urandom_range(0, 3)], 13'($urandom)};
  endfunction

  task automatic test_random();
    int          hit, ri;
    logic [31:0] exp_idx, exp_hi, exp_lo0, exp_lo1, hv;
    for (int it = 0; it < 400; it++) begin
      stall_i = ($urandom_range(0, 7) == 0); flush_i = ($urandom_range(0, 9) == 0);
      set_lookup($urandom_range(0, 1), rand_va(), $urandom_range(0, 1), $urandom_range(0, 1), rand_va());
      hv = rand_va();
      entryhi_i = {hv[31:13], 5'($urandom), ($urandom_range(0, 1) ? 8'd5 : 8'd6)};
      tlbwi_i = ($urandom_range(0, 5) == 0); tlbwr_i = ($urandom_range(0, 5) == 0);
      index_i = $urandom; random_i = $urandom; entrylo0_i = $urandom; entrylo1_i = $urandom;
      tlbp_i = $urandom_range(0, 1); tlbr_i = $urandom_range(0, 1);
      #1;
      hit = model_find(entryhi_i[31:13], entryhi_i[7:0]);
      exp_idx = !tlbp_i ? 32'h0 : (hit < 0 ? 32'h8000_0000 : 32'(hit));
      ri = int'(index_i % N);
      exp_hi  = tlbr_i ? ((32'(m_vpn2[ri]) << 13) | 32'(m_asid[ri])) : 32'h0;
      exp_lo0 = tlbr_i ? (m_lo[ri][0] | 32'(m_g[ri])) : 32'h0;
      exp_lo1 = tlbr_i ? (m_lo[ri][1] | 32'(m_g[ri])) : 32'h0;
      n_vec++; if (index_o !== exp_idx || tlbp_op_o !== tlbp_i) begin n_err++; $display("FAIL rnd_tlbp it%0d: got %h op=%b exp %h %b", it, index_o, tlbp_op_o, exp_idx, tlbp_i); end
      n_vec++; if ({entryhi_o, entrylo0_o, entrylo1_o} !== {exp_hi, exp_lo0, exp_lo1} || tlbr_op_o !== tlbr_i)
        begin n_err++; $display("FAIL rnd_tlbr it%0d: got %h %h %h exp %h %h %h", it, entryhi_o, entrylo0_o, entrylo1_o, exp_hi, exp_lo0, exp_lo1); end
      step();
      n_vec++; if ({lk.inst_valid_o, lk.inst_miss_o, lk.inst_invalid_o} !== {e_iv, e_imiss, e_iinv})
        begin n_err++; $display("FAIL rnd_inst_flags it%0d: got %b exp %b", it, {lk.inst_valid_o, lk.inst_miss_o, lk.inst_invalid_o}, {e_iv, e_imiss, e_iinv}); end
      n_vec++; if ({lk.data_valid_o, lk.data_miss_o, lk.data_invalid_o, lk.data_modified_o} !== {e_dv, e_dmiss, e_dinv, e_dmod})
        begin n_err++; $display("FAIL rnd_data_flags it%0d: got %b exp %b", it, {lk.data_valid_o, lk.data_miss_o, lk.data_invalid_o, lk.data_modified_o}, {e_dv, e_dmiss, e_dinv, e_dmod}); end
      if (e_iv) begin
        n_vec++; if (lk.inst_paddr_o !== e_ipa) begin n_err++; $display("FAIL rnd_inst_paddr it%0d: got %h exp %h", it, lk.inst_paddr_o, e_ipa); end
      end
      if (e_dv) begin
        n_vec++; if (lk.data_paddr_o !== e_dpa) begin n_err++; $display("FAIL rnd_data_paddr it%0d: got %h exp %h", it, lk.data_paddr_o, e_dpa); end
      end
    end
    clear_inputs();
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    clear_inputs(); model_clear();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_unmapped();
    test_tlbwi();
    test_tlbp_tlbr();
    test_asid_g();
    test_tlbwr();
    test_stall_flush();
    test_same_cycle_write();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
